// File: rtl/relu_backward_stream.sv
// ---------------------------------------------------------------------------
// relu_backward_stream
//
// Training-path companion to a ReLU activation. During the forward pass it
// streams ReLU(x) downstream while recording one sign-mask bit per element.
// During the backward pass it gates the incoming gradient stream with that
// mask. A tensor is one stream of NUM_ELEMS words.
//
// Optional feature macro: LEAKY_RELU_EN
//   defined   : the negative/zero path outputs x >>> 3 (slope 1/8)
//   undefined : the negative/zero path outputs 0 (plain ReLU)
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   fwd_start  : pulse, start forward capture (IDLE or MASKED only)
//   bwd_start  : pulse, start gradient pass (MASKED only)
//   in_valid   : input word valid
//   in_ready   : block accepts an input word this cycle
//   in_data    : signed activation (FWD) or gradient (BWD)
//   out_valid  : output register holds a word
//   out_ready  : downstream accepts the output word
//   out_data   : signed ReLU(x) (FWD) or gated gradient (BWD)
//   out_last   : output word is element NUM_ELEMS-1 of the pass
//   mask_valid : a complete mask is stored
//   busy       : a forward or backward pass is in progress
// ---------------------------------------------------------------------------
module relu_backward_stream #(
  parameter  int BIT_REP   = 8,
  parameter  int NUM_ELEMS = 64,
  localparam int CNT_W     = $clog2(NUM_ELEMS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fwd_start,
  input  logic                      bwd_start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BIT_REP-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BIT_REP-1:0] out_data,
  output logic                      out_last,
  output logic                      mask_valid,
  output logic                      busy
);

  localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(NUM_ELEMS);
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(NUM_ELEMS - 1);
  localparam logic signed [BIT_REP-1:0] ZERO_W   = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD    = 2'd1,
    ST_MASKED = 2'd2,
    ST_BWD    = 2'd3
  } state_t;

  state_t                      state_q,      state_d;
  logic [CNT_W-1:0]            cnt_q,        cnt_d;
  logic [NUM_ELEMS-1:0]        mask_q,       mask_d;
  logic                        mask_valid_q, mask_valid_d;
  logic                        out_valid_q,  out_valid_d;
  logic signed [BIT_REP-1:0]   out_data_q,   out_data_d;
  logic                        out_last_q,   out_last_d;

  logic                        busy_s;
  logic                        in_ready_s;
  logic                        accept_s;
  logic                        out_hs_s;
  logic [IDX_W-1:0]            idx_s;
  logic                        pos_s;
  logic                        sel_s;
  logic signed [BIT_REP-1:0]   neg_s;
  logic signed [BIT_REP-1:0]   gated_s;

  assign busy_s     = (state_q == ST_FWD) || (state_q == ST_BWD);
  // The counter saturates at NUM_ELEMS, which blocks input until the pass ends.
  assign in_ready_s = busy_s && (cnt_q < CNT_FULL) && (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_q && out_ready;
  assign idx_s      = cnt_q[IDX_W-1:0];
  // Zero counts as negative so it never opens the gradient gate.
  assign pos_s      = (in_data > ZERO_W);

  // Negative/zero-path value: leaky slope or plain zero.
  always_comb begin
`ifdef LEAKY_RELU_EN
    neg_s = in_data >>> 3'd3;
`else
    neg_s = ZERO_W;
`endif
  end

  // Select the pass-through condition (live sign in FWD, stored mask in BWD).
  always_comb begin
    if (state_q == ST_BWD) begin
      sel_s = mask_q[idx_s];
    end else begin
      sel_s = pos_s;
    end
    if (sel_s) begin
      gated_s = in_data;
    end else begin
      gated_s = neg_s;
    end
  end

  // Next-state logic for the pass FSM, mask store and output register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    mask_valid_d = mask_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    // Drain the output register; a new accept below refills it.
    if (out_hs_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gated_s;
      out_last_d  = (cnt_q == CNT_LAST);
      cnt_d       = cnt_q + CNT_W'(1);
    end else begin
      cnt_d       = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fwd_start) begin
          state_d      = ST_FWD;
          cnt_d        = '0;
          mask_valid_d = 1'b0;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_MASKED: begin
        // A simultaneous fwd_start takes priority over bwd_start.
        if (fwd_start) begin
          state_d      = ST_FWD;
          cnt_d        = '0;
          mask_valid_d = 1'b0;
        end else if (bwd_start) begin
          state_d      = ST_BWD;
          cnt_d        = '0;
        end else begin
          state_d      = ST_MASKED;
        end
      end
      ST_FWD: begin
        if (accept_s) begin
          mask_d[idx_s] = pos_s;
        end else begin
          mask_d = mask_q;
        end
        // The pass ends when the last word leaves, not when it arrives.
        if (out_hs_s && out_last_q) begin
          state_d      = ST_MASKED;
          mask_valid_d = 1'b1;
        end else begin
          state_d      = ST_FWD;
        end
      end
      ST_BWD: begin
        if (out_hs_s && out_last_q) begin
          state_d = ST_MASKED;
        end else begin
          state_d = ST_BWD;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        mask_valid_d = 1'b0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign mask_valid = mask_valid_q;
  assign busy       = busy_s;

endmodule

// File: tb/tb_relu_backward_stream.sv
// ---------------------------------------------------------------------------
// tb_relu_backward_stream
//
// Directed self-checking bench for relu_backward_stream with NUM_ELEMS=4.
// Expected values are hand-computed constants; the leaky variants are
// selected with LEAKY_RELU_EN to match the build of the design.
// ---------------------------------------------------------------------------
module tb_relu_backward_stream;

  localparam int BW = 8;
  localparam int NE = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 fwd_start;
  logic                 bwd_start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] out_data;
  logic                 out_last;
  logic                 mask_valid;
  logic                 busy;

  int n_cmp;
  int n_bad;

  relu_backward_stream #(.BIT_REP(BW), .NUM_ELEMS(NE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_start  (fwd_start),
    .bwd_start  (bwd_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .mask_valid (mask_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (mask_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mask_valid: got %b expected 0", mask_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (out_data !== 8'sd0) begin n_bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    rst_n = 1'b1;
    step();
    // bwd_start in IDLE must be ignored.
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_bwd_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_bwd_in_ready: got %b expected 0", in_ready); end
  endtask

  task automatic test_fwd();
    logic signed [BW-1:0] din [NE];
    logic signed [BW-1:0] dexp[NE];
    din[0] = 8'sd5; din[1] = -8'sd3; din[2] = 8'sd0; din[3] = 8'sd127;
`ifdef LEAKY_RELU_EN
    dexp[0] = 8'sd5; dexp[1] = -8'sd1; dexp[2] = 8'sd0; dexp[3] = 8'sd127;
`else
    dexp[0] = 8'sd5; dexp[1] = 8'sd0; dexp[2] = 8'sd0; dexp[3] = 8'sd127;
`endif
    out_ready = 1'b1;
    fwd_start = 1'b1;
    step();
    fwd_start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fwd_busy: got %b expected 1", busy); end
    n_cmp++; if (mask_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_mask_valid_low: got %b expected 0", mask_valid); end
    for (int i = 0; i < NE; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fwd_in_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_cmp++; if (out_data !== dexp[i]) begin n_bad++; $display("FAIL fwd_out_data[%0d]: got %0d expected %0d", i, out_data, dexp[i]); end
      n_cmp++; if (out_last !== (i == NE - 1)) begin n_bad++; $display("FAIL fwd_out_last[%0d]: got %b expected %b", i, out_last, (i == NE - 1)); end
    end
    // Keep offering a word: the saturated counter must refuse it.
    in_data = 8'sd77;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fwd_saturated_in_ready: got %b expected 0", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fwd_extra_word: got out_valid %b expected 0", out_valid); end
    n_cmp++; if (mask_valid !== 1'b1) begin n_bad++; $display("FAIL fwd_mask_valid: got %b expected 1", mask_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fwd_done_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bwd();
    logic signed [BW-1:0] din [NE];
    logic signed [BW-1:0] dexp[NE];
    din[0] = 8'sd10; din[1] = 8'sd10; din[2] = -8'sd8; din[3] = -8'sd128;
`ifdef LEAKY_RELU_EN
    dexp[0] = 8'sd10; dexp[1] = 8'sd1; dexp[2] = -8'sd1; dexp[3] = -8'sd128;
`else
    dexp[0] = 8'sd10; dexp[1] = 8'sd0; dexp[2] = 8'sd0; dexp[3] = -8'sd128;
`endif
    out_ready = 1'b1;
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bwd_busy: got %b expected 1", busy); end
    n_cmp++; if (mask_valid !== 1'b1) begin n_bad++; $display("FAIL bwd_mask_valid_kept: got %b expected 1", mask_valid); end
    for (int i = 0; i < NE; i++) begin
      in_valid = 1'b1;
      in_data  = din[i];
      step();
      n_cmp++; if (out_data !== dexp[i]) begin n_bad++; $display("FAIL bwd_out_data[%0d]: got %0d expected %0d", i, out_data, dexp[i]); end
      n_cmp++; if (out_last !== (i == NE - 1)) begin n_bad++; $display("FAIL bwd_out_last[%0d]: got %b expected %b", i, out_last, (i == NE - 1)); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bwd_done_busy: got %b expected 0", busy); end
    n_cmp++; if (mask_valid !== 1'b1) begin n_bad++; $display("FAIL bwd_done_mask_valid: got %b expected 1", mask_valid); end
  endtask

  task automatic test_backpressure();
    logic signed [BW-1:0] din [NE];
    logic signed [BW-1:0] dexp[NE];
    din[0] = 8'sd11; din[1] = 8'sd22; din[2] = 8'sd33; din[3] = 8'sd44;
`ifdef LEAKY_RELU_EN
    dexp[0] = 8'sd11; dexp[1] = 8'sd2; dexp[2] = 8'sd4; dexp[3] = 8'sd44;
`else
    dexp[0] = 8'sd11; dexp[1] = 8'sd0; dexp[2] = 8'sd0; dexp[3] = 8'sd44;
`endif
    out_ready = 1'b1;
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    in_valid = 1'b1;
    in_data  = din[0];
    step();
    n_cmp++; if (out_data !== dexp[0]) begin n_bad++; $display("FAIL bp_first_word: got %0d expected %0d", out_data, dexp[0]); end
    out_ready = 1'b0;
    in_data   = din[1];
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== dexp[0]) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid %b data %0d expected valid 1 data %0d", c, out_valid, out_data, dexp[0]); end
    end
    out_ready = 1'b1;
    for (int i = 1; i < NE; i++) begin
      in_data = din[i];
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== dexp[i]) begin n_bad++; $display("FAIL bp_resume[%0d]: got valid %b data %0d expected valid 1 data %0d", i, out_valid, out_data, dexp[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done: got busy %b out_valid %b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_fwd_in_bwd();
    logic signed [BW-1:0] din [NE];
    logic signed [BW-1:0] dexp[NE];
    din[0] = 8'sd10; din[1] = 8'sd10; din[2] = -8'sd8; din[3] = -8'sd128;
`ifdef LEAKY_RELU_EN
    dexp[0] = 8'sd10; dexp[1] = 8'sd1; dexp[2] = -8'sd1; dexp[3] = -8'sd128;
`else
    dexp[0] = 8'sd10; dexp[1] = 8'sd0; dexp[2] = 8'sd0; dexp[3] = -8'sd128;
`endif
    out_ready = 1'b1;
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      in_valid  = 1'b1;
      in_data   = din[i];
      fwd_start = (i == 1);
      step();
      fwd_start = 1'b0;
      n_cmp++; if (busy !== 1'b1 || mask_valid !== 1'b1) begin n_bad++; $display("FAIL fib_state[%0d]: got busy %b mask_valid %b expected 1 1", i, busy, mask_valid); end
      n_cmp++; if (out_data !== dexp[i]) begin n_bad++; $display("FAIL fib_out_data[%0d]: got %0d expected %0d", i, out_data, dexp[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || mask_valid !== 1'b1) begin n_bad++; $display("FAIL fib_done: got busy %b mask_valid %b expected 0 1", busy, mask_valid); end
  endtask

  task automatic test_reset_mid_fwd();
    out_ready = 1'b1;
    // Both starts together in MASKED: forward wins, mask invalidated.
    fwd_start = 1'b1;
    bwd_start = 1'b1;
    step();
    fwd_start = 1'b0;
    bwd_start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || mask_valid !== 1'b0) begin n_bad++; $display("FAIL both_start: got busy %b mask_valid %b expected 1 0", busy, mask_valid); end
    in_valid = 1'b1;
    in_data  = 8'sd9;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'sd9) begin n_bad++; $display("FAIL mid_fwd_word: got valid %b data %0d expected 1 9", out_valid, out_data); end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_out: got out_valid %b busy %b expected 0 0", out_valid, busy); end
    n_cmp++; if (mask_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_mask: got mask_valid %b in_ready %b expected 0 0", mask_valid, in_ready); end
    rst_n = 1'b1;
    step();
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_bwd_ignored: got busy %b expected 0", busy); end
  endtask

`ifdef LEAKY_RELU_EN
  task automatic test_leaky();
    logic signed [BW-1:0] fin [NE];
    logic signed [BW-1:0] fexp[NE];
    logic signed [BW-1:0] gin [NE];
    logic signed [BW-1:0] gexp[NE];
    fin[0] = -8'sd16; fin[1] = -8'sd1; fin[2] = 8'sd5; fin[3] = 8'sd0;
    fexp[0] = -8'sd2; fexp[1] = -8'sd1; fexp[2] = 8'sd5; fexp[3] = 8'sd0;
    gin[0] = -8'sd16; gin[1] = -8'sd1; gin[2] = 8'sd7; gin[3] = 8'sd8;
    gexp[0] = -8'sd2; gexp[1] = -8'sd1; gexp[2] = 8'sd7; gexp[3] = 8'sd1;
    out_ready = 1'b1;
    fwd_start = 1'b1;
    step();
    fwd_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      in_valid = 1'b1;
      in_data  = fin[i];
      step();
      n_cmp++; if (out_data !== fexp[i]) begin n_bad++; $display("FAIL leaky_fwd[%0d]: got %0d expected %0d", i, out_data, fexp[i]); end
    end
    in_valid = 1'b0;
    step();
    bwd_start = 1'b1;
    step();
    bwd_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      in_valid = 1'b1;
      in_data  = gin[i];
      step();
      n_cmp++; if (out_data !== gexp[i]) begin n_bad++; $display("FAIL leaky_bwd[%0d]: got %0d expected %0d", i, out_data, gexp[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || mask_valid !== 1'b1) begin n_bad++; $display("FAIL leaky_done: got busy %b mask_valid %b expected 0 1", busy, mask_valid); end
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    fwd_start = 1'b0;
    bwd_start = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'sd0;
    out_ready = 1'b1;
    test_reset();
    test_fwd();
    test_bwd();
    test_backpressure();
    test_fwd_in_bwd();
    test_reset_mid_fwd();
`ifdef LEAKY_RELU_EN
    test_leaky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
